// File: rtl/midi_uart_rx.sv
// MIDI 8N1 UART receiver: synchronises midi_rx, samples mid-bit, reports bytes and framing errors.
// Optional build macro MIDI_RX_MAJORITY_EN enables 2-of-3 majority voting on every bit decision.
module midi_uart_rx #(
  parameter int CLOCK_HZ     = 50000000,
  parameter int BAUD         = 31250,
  parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic       midi_rx,
  output logic [7:0] data_in,
  output logic       data_in_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_BIT = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                 rx_s, rx_prev, rx_bit, tick;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [7:0]           shift, shift_nxt, data_nxt;
  logic                 ready_nxt, fe_nxt;

  // Synchroniser resets to the idle-high level so reset release never fakes a start edge
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], midi_rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];

`ifdef MIDI_RX_MAJORITY_EN
  logic rx_prev2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) rx_prev2 <= 1'b1;
    else          rx_prev2 <= rx_prev;
  end

  assign rx_bit = majority3(rx_s, rx_prev, rx_prev2);
`else
  assign rx_bit = rx_s;
`endif

  assign tick = (timer == '0);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = tick ? timer : timer - 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    data_nxt    = data_in;
    ready_nxt   = 1'b0;
    fe_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s && rx_prev) begin
          state_nxt = START;
          timer_nxt = HALF_BIT;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_bit) begin
            state_nxt   = DATA;
            bit_idx_nxt = 3'd0;
            timer_nxt   = FULL_BIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = {rx_bit, shift[7:1]};
          timer_nxt = FULL_BIT;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid stop bit so the next start edge is never missed
        if (tick) begin
          if (rx_bit) begin
            data_nxt  = shift;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state         <= IDLE;
      timer         <= '0;
      bit_idx       <= 3'd0;
      shift         <= 8'h00;
      data_in       <= 8'h00;
      data_in_ready <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      bit_idx       <= bit_idx_nxt;
      shift         <= shift_nxt;
      data_in       <= data_nxt;
      data_in_ready <= ready_nxt;
      framing_error <= fe_nxt;
    end
  end

endmodule
